register_file_n: RTL and testbench
==================================

REGISTER_FILE_N -- requirements
Module: register_file_n

Interface
REQ-001 SHALL expose parameter NBITS, default 8, data width of every register and port.
REQ-002 SHALL expose parameter NUM_R, default 4, number of general registers R1..R(NUM_R).
REQ-003 SHALL expose parameter NUM_T, default 4, number of temporary registers T1..T(NUM_T).
REQ-004 SHALL expose parameter SAT, default 0; 0 = inc/dec wrap modulo 2^NBITS, 1 = inc/dec saturate at all-ones/zero.
REQ-005 SHALL expose derived parameter SW = ceil(log2(NUM_R+NUM_T)), the width of the read selects.
REQ-006 clock  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-008 i  input  NBITS  write data shared by all registers.
REQ-009 FunSel  input  2  operation applied to enabled registers: 00 decrement, 01 increment, 10 load i, 11 clear.
REQ-010 RSel  input  NUM_R  write-enable mask; MSB enables R1, LSB enables R(NUM_R).
REQ-011 TSel  input  NUM_T  write-enable mask; MSB enables T1, LSB enables T(NUM_T).
REQ-012 O1Sel  input  SW  read select, port 1: values 0..NUM_T-1 select T1..T(NUM_T), values NUM_T..NUM_T+NUM_R-1 select R1..R(NUM_R).
REQ-013 O2Sel  input  SW  read select, port 2, same encoding as O1Sel.
REQ-014 ClrOvf  input  1  clears the sticky overflow flag.
REQ-015 O1  output  NBITS  contents of the register chosen by O1Sel.
REQ-016 O2  output  NBITS  contents of the register chosen by O2Sel.
REQ-017 Ovf  output  1  sticky flag, set when any inc/dec wrapped or saturated.

Function
REQ-018 SHALL apply FunSel, in one clock edge, to every register whose mask bit is 1; registers whose mask bit is 0 SHALL hold.
REQ-019 SHALL allow any number of R and T registers to be enabled in the same cycle, including all registers and none.
REQ-020 O1 and O2 SHALL be combinational from current register state and the selects; a write becomes visible on O1/O2 in the cycle after the edge that performs it (no write-through bypass).
REQ-021 An out-of-range select value (>= NUM_R+NUM_T) SHALL drive the corresponding output to all zeros.
REQ-022 O1Sel and O2Sel SHALL be allowed to select the same register simultaneously, and both outputs SHALL then be equal.
REQ-023 With SAT=0, increment of all-ones SHALL yield 0, and decrement of 0 SHALL yield all-ones.
REQ-024 With SAT=1, increment of all-ones SHALL hold all-ones, and decrement of 0 SHALL hold 0.
REQ-025 Ovf SHALL be set on the edge where any enabled register hits a REQ-023/REQ-024 boundary; load and clear SHALL never set Ovf.
REQ-026 Ovf SHALL stay set until ClrOvf=1 or reset; if set and clear occur in the same cycle, set SHALL win.
REQ-027 All arithmetic SHALL be unsigned, NBITS wide, with no carry retained beyond Ovf.

Reset
REQ-028 While reset=1 at a rising edge, all registers and Ovf SHALL become 0, overriding FunSel, masks and ClrOvf.
REQ-029 Reset asserted mid-sequence SHALL discard any operation in that cycle; O1/O2 SHALL read 0 for every in-range select from the following cycle.
REQ-030 reset SHALL have no asynchronous effect; between edges, outputs SHALL follow register state only.

Verification
REQ-031 Default parameters, after reset: FunSel=10, i=0x5A, RSel=1000, TSel=0001 for one edge; then O1Sel=4 gives O1=0x5A and O2Sel=3 gives O2=0x5A, while all other registers read 0x00.
REQ-032 SAT=0: load R2=0xFF, then FunSel=01 on RSel=0100 gives O1(Sel=5)=0x00 and Ovf=1; then ClrOvf=1 for one edge with no inc/dec gives Ovf=0.
REQ-033 SAT=1: load T1=0x00, then FunSel=00 on TSel=1000 gives O1(Sel=0)=0x00 and Ovf=1; then increment gives 0x01.
REQ-034 All masks 1111/1111 with FunSel=10 and i=0x33, then FunSel=11 on RSel=0010 only: R3=0x00 and the other seven registers read 0x33.
REQ-035 Reset=1 in the same cycle as FunSel=10, i=0xAA, all masks set: all registers read 0x00 and Ovf=0 afterwards.
REQ-036 NUM_R=6, NUM_T=2, NBITS=16: load 0x1234 into R6 via RSel=000001; O1Sel=7 reads 0x1234, and O2Sel=8 (out of range) reads 0x0000.

Source files
------------

// File: rtl/register_file_n.sv
`default_nettype none
// ============================================================================
// Module   : register_file_n
// Brief    : NUM_T temporary plus NUM_R general registers. Masked inc/dec/load/clear
//            writes, two combinational read ports, and a sticky overflow flag.
// Revision : 1.0  initial release
// ============================================================================
module register_file_n #(
  parameter int NBITS = 8,
  parameter int NUM_R = 4,
  parameter int NUM_T = 4,
  parameter int SAT   = 0,
  parameter int SW    = (NUM_R + NUM_T > 1) ? $clog2(NUM_R + NUM_T) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:0] i,
  input  logic [1:0]       FunSel,
  input  logic [NUM_R-1:0] RSel,
  input  logic [NUM_T-1:0] TSel,
  input  logic [SW-1:0]    O1Sel,
  input  logic [SW-1:0]    O2Sel,
  input  logic             ClrOvf,
  output logic [NBITS-1:0] O1,
  output logic [NBITS-1:0] O2,
  output logic             Ovf
);

  localparam int               NREG     = NUM_R + NUM_T;
  localparam logic [NBITS-1:0] ZERO     = '0;
  localparam logic [NBITS-1:0] ONE      = NBITS'(1);
  localparam logic [NBITS-1:0] ALL_ONES = {NBITS{1'b1}};
  localparam logic [1:0]       FN_DEC   = 2'b00;
  localparam logic [1:0]       FN_INC   = 2'b01;
  localparam logic [1:0]       FN_LOAD  = 2'b10;

  logic [NBITS-1:0] regs_q [NREG];
  logic [NBITS-1:0] regs_d [NREG];
  logic [NREG-1:0]  wr_en;
  logic             ovf_q;
  logic             ovf_d;
  logic             ovf_hit;

  // Storage is ordered by read-select value: T1..T(NUM_T), then R1..R(NUM_R).
  for (genvar k = 0; k < NUM_T; k++) begin : g_t_en
    assign wr_en[k] = TSel[NUM_T-1-k];
  end
  for (genvar k = 0; k < NUM_R; k++) begin : g_r_en
    assign wr_en[NUM_T+k] = RSel[NUM_R-1-k];
  end

  always_comb begin
    ovf_hit = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      regs_d[k] = regs_q[k];
      if (wr_en[k]) begin
        case (FunSel)
          FN_DEC: begin
            if (regs_q[k] == ZERO) begin
              ovf_hit   = 1'b1;
              regs_d[k] = (SAT != 0) ? ZERO : ALL_ONES;
            end else begin
              regs_d[k] = regs_q[k] - ONE;
            end
          end
          FN_INC: begin
            if (regs_q[k] == ALL_ONES) begin
              ovf_hit   = 1'b1;
              regs_d[k] = (SAT != 0) ? ALL_ONES : ZERO;
            end else begin
              regs_d[k] = regs_q[k] + ONE;
            end
          end
          FN_LOAD: regs_d[k] = i;
          default: regs_d[k] = ZERO;
        endcase
      end
    end
    // A fresh boundary hit outranks a simultaneous clear request.
    ovf_d = ovf_hit | (ovf_q & ~ClrOvf);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= ZERO;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= regs_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    O1 = ZERO;
    O2 = ZERO;
    for (int k = 0; k < NREG; k++) begin
      if (O1Sel == SW'(k)) O1 = regs_q[k];
      if (O2Sel == SW'(k)) O2 = regs_q[k];
    end
  end

  assign Ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_n
// Brief    : Self-checking bench for register_file_n (wrap, saturate and 16-bit/6R/2T builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_register_file_n;

  logic clock = 1'b0;
  always #20 clock = ~clock;

  logic        reset, ClrOvf;
  logic [1:0]  FunSel;
  logic [7:0]  i;
  logic [3:0]  RSel, TSel;
  logic [2:0]  O1Sel, O2Sel;
  logic [7:0]  O1a, O2a, O1b, O2b;
  logic        Ovfa, Ovfb;
  logic [15:0] ic;
  logic [5:0]  RSelc;
  logic [1:0]  TSelc;
  logic [3:0]  O1Selc, O2Selc;
  logic [15:0] O1c, O2c;
  logic        Ovfc;

  int errors = 0;
  int checks = 0;

  // Reference state, indexed by register number as named in the register map.
  int mRa[1:4], mTa[1:4], mRb[1:4], mTb[1:4], mRc[1:6], mTc[1:2];
  bit ova, ovb, ovc;

  register_file_n dut_a (
    .clock(clock), .reset(reset), .i(i), .FunSel(FunSel), .RSel(RSel), .TSel(TSel),
    .O1Sel(O1Sel), .O2Sel(O2Sel), .ClrOvf(ClrOvf), .O1(O1a), .O2(O2a), .Ovf(Ovfa)
  );

  register_file_n #(.SAT(1)) dut_b (
    .clock(clock), .reset(reset), .i(i), .FunSel(FunSel), .RSel(RSel), .TSel(TSel),
    .O1Sel(O1Sel), .O2Sel(O2Sel), .ClrOvf(ClrOvf), .O1(O1b), .O2(O2b), .Ovf(Ovfb)
  );

  // Select width widened to 4 so that out-of-range value 8 can be driven.
  register_file_n #(.NBITS(16), .NUM_R(6), .NUM_T(2), .SW(4)) dut_c (
    .clock(clock), .reset(reset), .i(ic), .FunSel(FunSel), .RSel(RSelc), .TSel(TSelc),
    .O1Sel(O1Selc), .O2Sel(O2Selc), .ClrOvf(ClrOvf), .O1(O1c), .O2(O2c), .Ovf(Ovfc)
  );

  function automatic int op(input int v, input logic [1:0] fs, input int ld,
                            input int nb, input bit sat, output bit hit);
    int maxv = (1 << nb) - 1;
    int r;
    hit = 1'b0;
    case (fs)
      2'b00: if (v == 0) begin hit = 1'b1; r = sat ? 0 : maxv; end else r = v - 1;
      2'b01: if (v == maxv) begin hit = 1'b1; r = sat ? maxv : 0; end else r = v + 1;
      2'b10: r = ld;
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic model_step();
    bit h, ha, hb, hc;
    ha = 1'b0; hb = 1'b0; hc = 1'b0;
    if (reset) begin
      for (int n = 1; n <= 4; n++) begin mRa[n] = 0; mTa[n] = 0; mRb[n] = 0; mTb[n] = 0; end
      for (int n = 1; n <= 6; n++) mRc[n] = 0;
      for (int n = 1; n <= 2; n++) mTc[n] = 0;
      ova = 1'b0; ovb = 1'b0; ovc = 1'b0;
      return;
    end
    for (int n = 1; n <= 4; n++) begin
      if (RSel[4-n]) begin
        mRa[n] = op(mRa[n], FunSel, int'(i), 8, 1'b0, h); ha |= h;
        mRb[n] = op(mRb[n], FunSel, int'(i), 8, 1'b1, h); hb |= h;
      end
      if (TSel[4-n]) begin
        mTa[n] = op(mTa[n], FunSel, int'(i), 8, 1'b0, h); ha |= h;
        mTb[n] = op(mTb[n], FunSel, int'(i), 8, 1'b1, h); hb |= h;
      end
    end
    for (int n = 1; n <= 6; n++)
      if (RSelc[6-n]) begin mRc[n] = op(mRc[n], FunSel, int'(ic), 16, 1'b0, h); hc |= h; end
    for (int n = 1; n <= 2; n++)
      if (TSelc[2-n]) begin mTc[n] = op(mTc[n], FunSel, int'(ic), 16, 1'b0, h); hc |= h; end
    ova = ha || (ova && !ClrOvf);
    ovb = hb || (ovb && !ClrOvf);
    ovc = hc || (ovc && !ClrOvf);
  endtask

  function automatic int exp_ab(input int sel, input bit b);
    if (sel < 4) return b ? mTb[sel+1] : mTa[sel+1];
    return b ? mRb[sel-3] : mRa[sel-3];
  endfunction

  function automatic int exp_c(input int sel);
    if (sel < 2) return mTc[sel+1];
    if (sel < 8) return mRc[sel-1];
    return 0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    reset = 1'b0; ClrOvf = 1'b0; FunSel = 2'b00;
    RSel = '0; TSel = '0; RSelc = '0; TSelc = '0;
  endtask

  task automatic check_ab(input string tag);
    for (int s = 0; s < 8; s++) begin
      O1Sel = 3'(s);
      O2Sel = (s % 2 == 0) ? 3'(s) : 3'(7 - s);
      #1;
      checks += 4;
      if (O1a !== 8'(exp_ab(s, 1'b0))) begin errors++;
        $display("FAIL %s O1a sel=%0d got=%h exp=%h", tag, s, O1a, 8'(exp_ab(s, 1'b0))); end
      if (O2a !== 8'(exp_ab(int'(O2Sel), 1'b0))) begin errors++;
        $display("FAIL %s O2a sel=%0d got=%h exp=%h", tag, O2Sel, O2a, 8'(exp_ab(int'(O2Sel), 1'b0))); end
      if (O1b !== 8'(exp_ab(s, 1'b1))) begin errors++;
        $display("FAIL %s O1b sel=%0d got=%h exp=%h", tag, s, O1b, 8'(exp_ab(s, 1'b1))); end
      if (O2b !== 8'(exp_ab(int'(O2Sel), 1'b1))) begin errors++;
        $display("FAIL %s O2b sel=%0d got=%h exp=%h", tag, O2Sel, O2b, 8'(exp_ab(int'(O2Sel), 1'b1))); end
    end
    checks += 2;
    if (Ovfa !== ova) begin errors++; $display("FAIL %s Ovfa got=%b exp=%b", tag, Ovfa, ova); end
    if (Ovfb !== ovb) begin errors++; $display("FAIL %s Ovfb got=%b exp=%b", tag, Ovfb, ovb); end
  endtask

  task automatic check_c(input string tag);
    for (int s = 0; s < 16; s++) begin
      O1Selc = 4'(s);
      O2Selc = 4'(15 - s);
      #1;
      checks += 2;
      if (O1c !== 16'(exp_c(s))) begin errors++;
        $display("FAIL %s O1c sel=%0d got=%h exp=%h", tag, s, O1c, 16'(exp_c(s))); end
      if (O2c !== 16'(exp_c(15 - s))) begin errors++;
        $display("FAIL %s O2c sel=%0d got=%h exp=%h", tag, 15 - s, O2c, 16'(exp_c(15 - s))); end
    end
    checks += 1;
    if (Ovfc !== ovc) begin errors++; $display("FAIL %s Ovfc got=%b exp=%b", tag, Ovfc, ovc); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    check_ab("reset");
    check_c("reset");
  endtask

  task automatic test_load_pair();
    FunSel = 2'b10; i = 8'h5A; RSel = 4'b1000; TSel = 4'b0001;
    tick();
    O1Sel = 3'd4; O2Sel = 3'd3; #1;
    checks += 2;
    if (O1a !== 8'h5A) begin errors++; $display("FAIL load_R1 got=%h exp=5a", O1a); end
    if (O2a !== 8'h5A) begin errors++; $display("FAIL load_T4 got=%h exp=5a", O2a); end
    check_ab("load_pair");
  endtask

  task automatic test_boundaries();
    FunSel = 2'b10; i = 8'hFF; RSel = 4'b0100;
    tick();
    FunSel = 2'b01; RSel = 4'b0100;
    tick();
    O1Sel = 3'd5; #1;
    checks += 4;
    if (O1a !== 8'h00) begin errors++; $display("FAIL wrap_inc got=%h exp=00", O1a); end
    if (Ovfa !== 1'b1) begin errors++; $display("FAIL wrap_ovf got=%b exp=1", Ovfa); end
    if (O1b !== 8'hFF) begin errors++; $display("FAIL sat_inc got=%h exp=ff", O1b); end
    if (Ovfb !== 1'b1) begin errors++; $display("FAIL sat_inc_ovf got=%b exp=1", Ovfb); end
    ClrOvf = 1'b1;
    tick();
    checks += 1;
    if (Ovfa !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%b exp=0", Ovfa); end
    check_ab("clr_ovf");
    FunSel = 2'b10; i = 8'h00; TSel = 4'b1000;
    tick();
    FunSel = 2'b00; TSel = 4'b1000;
    tick();
    O1Sel = 3'd0; #1;
    checks += 3;
    if (O1b !== 8'h00) begin errors++; $display("FAIL sat_dec got=%h exp=00", O1b); end
    if (Ovfb !== 1'b1) begin errors++; $display("FAIL sat_dec_ovf got=%b exp=1", Ovfb); end
    if (O1a !== 8'hFF) begin errors++; $display("FAIL wrap_dec got=%h exp=ff", O1a); end
    FunSel = 2'b01; TSel = 4'b1000;
    tick();
    O1Sel = 3'd0; #1;
    checks += 1;
    if (O1b !== 8'h01) begin errors++; $display("FAIL sat_then_inc got=%h exp=01", O1b); end
    // R2 now 00 in the wrapping copy, FF in the saturating copy.
    FunSel = 2'b01; RSel = 4'b0100; ClrOvf = 1'b1;
    tick();
    checks += 2;
    if (Ovfa !== 1'b0) begin errors++; $display("FAIL clr_no_hit got=%b exp=0", Ovfa); end
    if (Ovfb !== 1'b1) begin errors++; $display("FAIL set_beats_clr got=%b exp=1", Ovfb); end
    check_ab("boundaries");
  endtask

  task automatic test_all_masks();
    FunSel = 2'b10; i = 8'h33; RSel = 4'b1111; TSel = 4'b1111;
    tick();
    FunSel = 2'b11; RSel = 4'b0010;
    tick();
    for (int s = 0; s < 8; s++) begin
      O1Sel = 3'(s); #1;
      checks += 1;
      if (O1a !== ((s == 6) ? 8'h00 : 8'h33)) begin errors++;
        $display("FAIL clear_R3 sel=%0d got=%h exp=%h", s, O1a, (s == 6) ? 8'h00 : 8'h33); end
    end
    check_ab("all_masks");
  endtask

  task automatic test_async_free_reset();
    reset = 1'b1;
    check_ab("reset_between_edges");
    FunSel = 2'b10; i = 8'hAA; RSel = 4'b1111; TSel = 4'b1111; ClrOvf = 1'b0;
    tick();
    for (int s = 0; s < 8; s++) begin
      O1Sel = 3'(s); #1;
      checks += 2;
      if (O1a !== 8'h00) begin errors++; $display("FAIL reset_override_a sel=%0d got=%h exp=00", s, O1a); end
      if (O1b !== 8'h00) begin errors++; $display("FAIL reset_override_b sel=%0d got=%h exp=00", s, O1b); end
    end
    checks += 2;
    if (Ovfa !== 1'b0) begin errors++; $display("FAIL reset_ovf_a got=%b exp=0", Ovfa); end
    if (Ovfb !== 1'b0) begin errors++; $display("FAIL reset_ovf_b got=%b exp=0", Ovfb); end
    check_c("reset_override");
  endtask

  task automatic test_wide_config();
    FunSel = 2'b10; ic = 16'h1234; RSelc = 6'b000001;
    tick();
    O1Selc = 4'd7; O2Selc = 4'd8; #1;
    checks += 2;
    if (O1c !== 16'h1234) begin errors++; $display("FAIL wide_R6 got=%h exp=1234", O1c); end
    if (O2c !== 16'h0000) begin errors++; $display("FAIL wide_oor got=%h exp=0000", O2c); end
    check_c("wide");
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 3))
      0: return 8'h00;
      1: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 250; n++) begin
      reset  = ($urandom_range(0, 31) == 0);
      FunSel = 2'($urandom);
      i      = pick8();
      RSel   = 4'($urandom);
      TSel   = 4'($urandom);
      ClrOvf = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: ic = 16'h0000;
        1: ic = 16'hFFFF;
        default: ic = 16'($urandom);
      endcase
      RSelc = 6'($urandom);
      TSelc = 2'($urandom);
      tick();
      check_ab("random");
      check_c("random");
    end
  endtask

  initial begin
    reset = 1'b0; ClrOvf = 1'b0; FunSel = 2'b00; i = '0; RSel = '0; TSel = '0;
    O1Sel = '0; O2Sel = '0; ic = '0; RSelc = '0; TSelc = '0; O1Selc = '0; O2Selc = '0;
    test_reset();
    test_load_pair();
    test_boundaries();
    test_all_masks();
    test_async_free_reset();
    test_wide_config();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
